// File: rtl/memory_1r1w.sv
// Single-clock 1-read/1-write memory with byte enables, write-first forwarding and a
// post-reset clear sequence. Define MEMORY_PARITY_EN to add per-byte even parity.
module memory_1r1w #(
  parameter int addr_p       = 10,
  parameter int data_width_p = 32,
  parameter int rd_lat_p     = 1
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      wr_req_i,
  input  logic [addr_p-1:0]         wr_addr_i,
  input  logic [data_width_p-1:0]   wr_data_i,
  input  logic [data_width_p/8-1:0] wr_be_i,
  output logic                      wr_ready_o,
  input  logic                      rd_req_i,
  input  logic [addr_p-1:0]         rd_addr_i,
  output logic                      rd_ready_o,
  output logic                      rd_valid_o,
  output logic [data_width_p-1:0]   rd_data_o,
  output logic                      init_done_o,
  output logic                      par_err_o
);

  localparam int depth_lp  = 2**addr_p;
  localparam int nbytes_lp = data_width_p/8;

  if (data_width_p % 8 != 0) begin : g_bad_width
    $error("memory_1r1w: data_width_p must be a multiple of 8");
  end
  if (rd_lat_p != 1 && rd_lat_p != 2) begin : g_bad_lat
    $error("memory_1r1w: rd_lat_p must be 1 or 2");
  end

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [addr_p-1:0] clr_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= INIT;
      clr_cnt     <= '0;
      wr_ready_o  <= 1'b0;
      rd_ready_o  <= 1'b0;
      init_done_o <= 1'b0;
    end else if (state == INIT) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == '1) begin
        state       <= RUN;
        wr_ready_o  <= 1'b1;
        rd_ready_o  <= 1'b1;
        init_done_o <= 1'b1;
      end
    end
  end

  logic wr_fire, rd_fire, init_wr;
  assign wr_fire = wr_req_i & wr_ready_o;
  assign rd_fire = rd_req_i & rd_ready_o;
  assign init_wr = (state == INIT);

  // The clear sequence borrows the write port with all lanes enabled and zero data.
  logic [addr_p-1:0]       w_addr;
  logic [data_width_p-1:0] w_data;
  logic [nbytes_lp-1:0]    w_be;
  assign w_addr = init_wr ? clr_cnt : wr_addr_i;
  assign w_data = init_wr ? '0 : wr_data_i;
  assign w_be   = init_wr ? '1 : (wr_fire ? wr_be_i : '0);

  logic [data_width_p-1:0] mem [depth_lp];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < nbytes_lp; b++) begin
      if (w_be[b]) mem[w_addr][8*b +: 8] <= w_data[8*b +: 8];
    end
  end

  logic [nbytes_lp-1:0]    fwd_be;
  logic [data_width_p-1:0] rd_old, rd_word;
  assign fwd_be = (wr_fire && (wr_addr_i == rd_addr_i)) ? wr_be_i : '0;
  assign rd_old = mem[rd_addr_i];

  always_comb begin
    rd_word = rd_old;
    for (int b = 0; b < nbytes_lp; b++) begin
      if (fwd_be[b]) rd_word[8*b +: 8] = wr_data_i[8*b +: 8];
    end
  end

  // Data registers only load on an accepted read so the output holds between beats.
  logic                    s1_valid;
  logic [data_width_p-1:0] s1_data;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) s1_data <= rd_word;
    end
  end

  if (rd_lat_p == 2) begin : g_lat2
    logic                    s2_valid;
    logic [data_width_p-1:0] s2_data;
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end
    assign rd_valid_o = s2_valid;
    assign rd_data_o  = s2_data;
  end else begin : g_lat1
    assign rd_valid_o = s1_valid;
    assign rd_data_o  = s1_data;
  end

`ifdef MEMORY_PARITY_EN
  logic [nbytes_lp-1:0] par_mem [depth_lp];
  logic [nbytes_lp-1:0] rd_par_old;
  logic                 rd_perr, s1_perr;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < nbytes_lp; b++) begin
      if (w_be[b]) par_mem[w_addr][b] <= ^w_data[8*b +: 8];
    end
  end

  assign rd_par_old = par_mem[rd_addr_i];

  // Forwarded lanes carry fresh data, so only lanes coming from storage are checked.
  always_comb begin
    rd_perr = 1'b0;
    for (int b = 0; b < nbytes_lp; b++) begin
      if (!fwd_be[b] && ((^rd_old[8*b +: 8]) != rd_par_old[b])) rd_perr = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) s1_perr <= 1'b0;
    else         s1_perr <= rd_fire & rd_perr;
  end

  if (rd_lat_p == 2) begin : g_perr2
    logic s2_perr;
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) s2_perr <= 1'b0;
      else         s2_perr <= s1_perr;
    end
    assign par_err_o = s2_perr;
  end else begin : g_perr1
    assign par_err_o = s1_perr;
  end
`else
  assign par_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_memory_1r1w.sv
// Directed self-checking bench for memory_1r1w (addr_p=4, 32-bit words, read latency 2).
module tb_memory_1r1w;

  localparam int ADDR = 4;
  localparam int LAT  = 2;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        wr_req_i;
  logic [3:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic [3:0]  wr_be_i;
  logic        wr_ready_o;
  logic        rd_req_i;
  logic [3:0]  rd_addr_i;
  logic        rd_ready_o;
  logic        rd_valid_o;
  logic [31:0] rd_data_o;
  logic        init_done_o;
  logic        par_err_o;

  int checks = 0;
  int errors = 0;

  memory_1r1w #(.addr_p(ADDR), .data_width_p(32), .rd_lat_p(LAT)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_be_i(wr_be_i),
    .wr_ready_o(wr_ready_o),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_ready_o(rd_ready_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .init_done_o(init_done_o), .par_err_o(par_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of requests from a falling edge and returns at the next falling edge.
  task automatic applyStimulus(input logic wr, input logic [3:0] wa, input logic [31:0] wd,
                               input logic [3:0] be, input logic rd, input logic [3:0] ra);
    wr_req_i  = wr;
    wr_addr_i = wa;
    wr_data_i = wd;
    wr_be_i   = be;
    rd_req_i  = rd;
    rd_addr_i = ra;
    @(posedge clk_i);
    @(negedge clk_i);
    wr_req_i = 1'b0;
    rd_req_i = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
  endtask

  task automatic writeWord(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    applyStimulus(1'b1, a, d, be, 1'b0, 4'h0);
  endtask

  task automatic readCheck(input string tag, input logic [3:0] a, input logic [31:0] exp_data,
                           input logic exp_perr);
    int n;
    applyStimulus(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, a);
    n = 1;
    while (!rd_valid_o && n < 8) begin
      idle();
      n++;
    end
    checkOutput({tag, "_lat"}, n, LAT);
    checkOutput({tag, "_data"}, rd_data_o, exp_data);
    checkOutput({tag, "_perr"}, {31'b0, par_err_o}, {31'b0, exp_perr});
    idle();
    checkOutput({tag, "_pulse"}, {31'b0, rd_valid_o}, 32'h0);
    checkOutput({tag, "_perr_after"}, {31'b0, par_err_o}, 32'h0);
  endtask

  task automatic waitInit(input string tag);
    int n;
    n = 0;
    checkOutput({tag, "_done_at_release"}, {31'b0, init_done_o}, 32'h0);
    while (!init_done_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput({tag, "_init_len"}, n, 16);
    checkOutput({tag, "_wr_ready"}, {31'b0, wr_ready_o}, 32'h1);
    checkOutput({tag, "_rd_ready"}, {31'b0, rd_ready_o}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int vcount;
    rstn_i = 1'b0;
    wr_req_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; wr_be_i = '0;
    rd_req_i = 1'b0; rd_addr_i = '0;

    // Reset and clear sequence
    repeat (3) @(negedge clk_i);
    checkOutput("rst_wr_ready", {31'b0, wr_ready_o}, 32'h0);
    checkOutput("rst_rd_ready", {31'b0, rd_ready_o}, 32'h0);
    checkOutput("rst_rd_valid", {31'b0, rd_valid_o}, 32'h0);
    checkOutput("rst_rd_data", rd_data_o, 32'h0);
    checkOutput("rst_init_done", {31'b0, init_done_o}, 32'h0);
    checkOutput("rst_par_err", {31'b0, par_err_o}, 32'h0);
    rstn_i = 1'b1;
    waitInit("t1");
    for (int a = 0; a < 16; a++) readCheck("t1_zero", a[3:0], 32'h0, 1'b0);

    // Byte-merge write
    writeWord(4'd5, 32'hDEADBEEF, 4'hF);
    writeWord(4'd5, 32'h000000AA, 4'b0001);
    readCheck("t2_merge", 4'd5, 32'hDEADBEAA, 1'b0);

    // Back-to-back pipelined reads
    writeWord(4'd1, 32'h11, 4'hF);
    writeWord(4'd2, 32'h22, 4'hF);
    writeWord(4'd3, 32'h33, 4'hF);
    applyStimulus(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd1);
    checkOutput("t3_v0", {31'b0, rd_valid_o}, 32'h0);
    applyStimulus(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd2);
    checkOutput("t3_v1", {31'b0, rd_valid_o}, 32'h1);
    checkOutput("t3_d1", rd_data_o, 32'h11);
    applyStimulus(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd3);
    checkOutput("t3_v2", {31'b0, rd_valid_o}, 32'h1);
    checkOutput("t3_d2", rd_data_o, 32'h22);
    idle();
    checkOutput("t3_v3", {31'b0, rd_valid_o}, 32'h1);
    checkOutput("t3_d3", rd_data_o, 32'h33);
    idle();
    checkOutput("t3_v4", {31'b0, rd_valid_o}, 32'h0);
    checkOutput("t3_hold", rd_data_o, 32'h33);

    // Write-first collision, then independent read/write on different addresses
    writeWord(4'd7, 32'h11223344, 4'hF);
    applyStimulus(1'b1, 4'd7, 32'hAABBCCDD, 4'b1100, 1'b1, 4'd7);
    idle();
    checkOutput("t4_coll_valid", {31'b0, rd_valid_o}, 32'h1);
    checkOutput("t4_coll_data", rd_data_o, 32'hAABB3344);
    checkOutput("t4_coll_perr", {31'b0, par_err_o}, 32'h0);
    readCheck("t4_after", 4'd7, 32'hAABB3344, 1'b0);
    applyStimulus(1'b1, 4'd8, 32'h00000055, 4'hF, 1'b1, 4'd7);
    idle();
    checkOutput("t4_indep_data", rd_data_o, 32'hAABB3344);
    readCheck("t4_indep_wr", 4'd8, 32'h00000055, 1'b0);

    // Reset with a read in flight
    applyStimulus(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd5);
    #1 rstn_i = 1'b0;
    #1;
    checkOutput("t5_valid_now", {31'b0, rd_valid_o}, 32'h0);
    checkOutput("t5_data_now", rd_data_o, 32'h0);
    checkOutput("t5_init_done", {31'b0, init_done_o}, 32'h0);
    checkOutput("t5_wr_ready", {31'b0, wr_ready_o}, 32'h0);
    vcount = 0;
    repeat (2) begin
      @(negedge clk_i);
      if (rd_valid_o) vcount++;
    end
    rstn_i = 1'b1;
    fork
      waitInit("t5");
      repeat (20) begin
        @(negedge clk_i);
        if (rd_valid_o) vcount++;
      end
    join
    checkOutput("t5_no_pulse", vcount, 0);
    readCheck("t5_cleared", 4'd5, 32'h0, 1'b0);

    // Parity error injection
    writeWord(4'd3, 32'h0F0F0F0F, 4'hF);
`ifdef MEMORY_PARITY_EN
    dut.mem[3][0] = ~dut.mem[3][0];
    readCheck("t6_par", 4'd3, 32'h0F0F0F0E, 1'b1);
`else
    readCheck("t6_nopar", 4'd3, 32'h0F0F0F0F, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
